// File: rtl/rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: segment sizing and a
// reference segment add for use alongside the fulladder-based datapath.
package rca_pkg;

  localparam int unsigned SEG_MAX = 64;

  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Returns {cout, sum} for a segment of up to SEG_MAX bits (zero-extend narrower operands).
  function automatic logic [SEG_MAX:0] seg_add(input logic [SEG_MAX-1:0] a,
                                               input logic [SEG_MAX-1:0] b,
                                               input logic               cin);
    return {1'b0, a} + {1'b0, b} + {{SEG_MAX{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder, the ripple element of rca_segment.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple adder; also exposes the carry into the top bit
// so the final stage can form signed overflow.
module rca_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, with
// operands and partial sums skewed alongside so each stage holds a whole op.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("rca_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             c_msb;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t stage_q [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [SEG-1:0] seg_a  [STAGES];
  logic [SEG-1:0] seg_b  [STAGES];
  logic [SEG-1:0] seg_s  [STAGES];
  logic           seg_ci [STAGES];
  logic           seg_co [STAGES];
  logic           seg_cm [STAGES];

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign c0       = in_sub | in_cin;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign seg_a[g]  = in_a[SEG-1:0];
      assign seg_b[g]  = b_eff[SEG-1:0];
      assign seg_ci[g] = c0;
    end else begin : g_next
      assign seg_a[g]  = stage_q[g-1].a[g*SEG +: SEG];
      assign seg_b[g]  = stage_q[g-1].b[g*SEG +: SEG];
      assign seg_ci[g] = stage_q[g-1].carry;
    end

    rca_segment #(.SEG(SEG)) u_seg (
      .a        (seg_a[g]),
      .b        (seg_b[g]),
      .cin      (seg_ci[g]),
      .s        (seg_s[g]),
      .cout     (seg_co[g]),
      .c_msb_in (seg_cm[g])
    );
  end

  // Whole pipeline moves together: a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      stage_q[0].valid          <= in_valid;
      stage_q[0].carry          <= seg_co[0];
      stage_q[0].c_msb          <= seg_cm[0];
      stage_q[0].a              <= in_a;
      stage_q[0].b              <= b_eff;
      stage_q[0].sum            <= '0;
      stage_q[0].sum[SEG-1:0]   <= seg_s[0];
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage_q[k]                 <= stage_q[k-1];
        stage_q[k].carry           <= seg_co[k];
        stage_q[k].c_msb           <= seg_cm[k];
        stage_q[k].sum[k*SEG +: SEG] <= seg_s[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_sum   = stage_q[STAGES-1].sum;
  assign out_cout  = stage_q[STAGES-1].carry;
  assign out_ovf   = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].c_msb;

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: expected results queued at acceptance and
// compared in order at the output; extra small instances cover degenerate shapes.
module tb_rca_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_sub, in_cin;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  logic       s_valid, s_sub, s_cin, s_rdy;
  logic [7:0] s_a, s_b;
  logic       v8_irdy, v8_valid, v8_cout, v8_ovf;
  logic [7:0] v8_sum;
  logic       v1_irdy, v1_valid, v1_cout, v1_ovf;
  logic [7:0] v1_sum;

  always #5 clk = ~clk;

  rca_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  rca_pipe #(.WIDTH(8), .STAGES(8)) dut_w8s8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(v8_irdy), .in_a(s_a), .in_b(s_b),
    .in_sub(s_sub), .in_cin(s_cin),
    .out_valid(v8_valid), .out_ready(s_rdy), .out_sum(v8_sum),
    .out_cout(v8_cout), .out_ovf(v8_ovf)
  );

  rca_pipe #(.WIDTH(8), .STAGES(1)) dut_w8s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(v1_irdy), .in_a(s_a), .in_b(s_b),
    .in_sub(s_sub), .in_cin(s_cin),
    .out_valid(v1_valid), .out_ready(s_rdy), .out_sum(v1_sum),
    .out_cout(v1_cout), .out_ovf(v1_ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_out   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic; overflow from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      sb.push_back(model(in_a, in_b, in_sub, in_cin));
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_sum", out_sum, mon_e.sum);
        chk("sb_cout", out_cout, mon_e.cout);
        chk("sb_ovf", out_ovf, mon_e.ovf);
        n_out++;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic cin);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input logic [W-1:0] e_sum,
                         input logic e_cout, input logic e_ovf);
    int unsigned lat;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, S);
    chk({tag, "_sum"}, out_sum, e_sum);
    chk({tag, "_cout"}, out_cout, e_cout);
    chk({tag, "_ovf"}, out_ovf, e_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned n0, extra, v_cnt, l8, l1;
    logic [W-1:0] cap_sum;
    logic         cap_cout, cap_ovf;
    logic [7:0]   sum8, sum1;
    logic         co8, co1, ov8, ov1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    s_valid = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_rdy = 1'b1; s_a = '0; s_b = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: carry across a segment boundary, subtract, signed overflow.
    run_one("t1_add", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    run_one("t2_sub", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("t2_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("t2_cin", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    drain("t2_drain");

    // Back-to-back random stream.
    n0 = n_out;
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    extra = 0;
    while (sb.size() != 0 && extra < 50) begin
      @(posedge clk); #1;
      extra++;
    end
    chk("t3_tail_cycles", extra, S);
    chk("t3_count", n_out - n0, 100);

    // Backpressure: output stalls for three cycles mid-stream.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        out_ready = 1'b0;
        chk("t4_stall_valid", out_valid, 1);
        cap_sum = out_sum; cap_cout = out_cout; cap_ovf = out_ovf;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t4_in_ready", in_ready, 0);
          chk("t4_hold_valid", out_valid, 1);
          chk("t4_hold_sum", out_sum, cap_sum);
          chk("t4_hold_cout", out_cout, cap_cout);
          chk("t4_hold_ovf", out_ovf, cap_ovf);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
    join
    drain("t4_drain");
    chk("t4_count", n_out - n0, 30);

    // Reset with ops in flight: everything discarded.
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    v_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) v_cnt++;
    end
    chk("t5_no_stale", v_cnt, 0);

    // Degenerate shapes: one bit per stage, and a single registered adder.
    @(posedge clk); #1;
    s_a = 8'hFF; s_b = 8'h01; s_cin = 1'b1; s_sub = 1'b0; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    l8 = 0; l1 = 0;
    sum8 = '0; sum1 = '0; co8 = 1'b0; co1 = 1'b0; ov8 = 1'b1; ov1 = 1'b1;
    for (int unsigned lat = 1; lat <= 20; lat++) begin
      if (v1_valid && l1 == 0) begin l1 = lat; sum1 = v1_sum; co1 = v1_cout; ov1 = v1_ovf; end
      if (v8_valid && l8 == 0) begin l8 = lat; sum8 = v8_sum; co8 = v8_cout; ov8 = v8_ovf; end
      @(posedge clk); #1;
    end
    chk("t6_s8_lat", l8, 8);
    chk("t6_s8_sum", sum8, 8'h01);
    chk("t6_s8_cout", co8, 1);
    chk("t6_s8_ovf", ov8, 0);
    chk("t6_s1_lat", l1, 1);
    chk("t6_s1_sum", sum1, 8'h01);
    chk("t6_s1_cout", co1, 1);
    chk("t6_s1_ovf", ov1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
